// File: rtl/chan_mux_scan.sv
// rtl/chan_mux_scan.sv - registered CH-way channel selector with direct/scan indexing and valid/ready output
// Optional CHAN_MUX_MASK_EN adds ch_mask so scan mode skips disabled channels.
module chan_mux_scan #(
  parameter int CH = 4,
  parameter int W  = 1,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] data,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            flag,
  input  logic            out_ready,
`ifdef CHAN_MUX_MASK_EN
  input  logic [CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  output logic            out_last
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q;
  logic [W-1:0]    out_data_q;
  logic [SW-1:0]   out_ch_q;
  logic            out_last_q;
  logic [SW-1:0]   scan_q, scan_d;

  logic [CH-1:0]   mask;
  logic [SW-1:0]   idx;
  logic [SW-1:0]   hi;
  logic            found;
  logic            last_c;
  logic [W-1:0]    word;
  logic            accept;
  logic            capture;

`ifdef CHAN_MUX_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  // Cyclic search from scan_q: walking k downward lets the nearest enabled channel win.
  always_comb begin
    idx    = sel;
    hi     = '0;
    found  = 1'b1;
    last_c = 1'b0;
    if (mode) begin
      found = 1'b0;
      idx   = scan_q;
      for (int k = CH - 1; k >= 0; k--) begin
        if (mask[(int'(scan_q) + k) % CH]) begin
          found = 1'b1;
          idx   = SW'((int'(scan_q) + k) % CH);
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (mask[i]) hi = SW'(i);
      end
      last_c = found && (idx == hi);
    end
  end

  // Indices beyond CH-1 (non power-of-2 CH) fall through to a zero word.
  always_comb begin
    word = '0;
    for (int i = 0; i < CH; i++) begin
      if (idx == SW'(i)) word = data[i*W +: W];
    end
  end

  assign accept  = (state_q == FULL) && out_ready;
  assign capture = flag && found && ((state_q == EMPTY) || out_ready);

  always_comb begin
    scan_d = scan_q;
    if (!mode) begin
      scan_d = '0;
    end else if (capture) begin
      scan_d = (idx == SW'(CH - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_last_q <= 1'b0;
      scan_q     <= '0;
    end else begin
      scan_q <= scan_d;
      if (capture) begin
        state_q    <= FULL;
        out_data_q <= word;
        out_ch_q   <= idx;
        out_last_q <= mode && last_c;
      end else if (accept) begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = (state_q == FULL);
  assign out_last  = out_last_q;

endmodule

// File: doc/chan_mux_scan.md
# chan_mux_scan

Parametrised, registered channel selector with a valid/ready output. It picks one W-bit channel out of CH packed input channels, either by direct index or by an internal round-robin scan, and presents the selected word with its channel number. It is the clocked, multi-bit, multi-channel successor to the lab's single-bit 4:1 gated mux. It sits between a bank of parallel sources (switches, counters, sensor bits) and a single serial consumer (display driver, UART framer).

## Interface
- CH, default 4: number of input channels, 2..16.
- W, default 1: width of each channel word, 1..32.
- SW (localparam): $clog2(CH), width of channel indices.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data  in  CH*W  packed channels; channel i at data[i*W +: W]
- sel  in  SW  channel index, used in direct mode
- mode  in  1  0 = direct (use sel), 1 = scan (internal index)
- flag  in  1  capture enable; no new word is captured while 0
- out_ready  in  1  consumer accepts the current word
- out_data  out  W  captured channel word
- out_ch  out  SW  channel index of out_data
- out_valid  out  1  out_data/out_ch hold an unaccepted word
- out_last  out  1  current word is channel CH-1 captured in scan mode
- ch_mask  in  CH  per-channel scan enable; present only with CHAN_MUX_MASK_EN

## Operation
- Reset: out_data=0, out_ch=0, out_valid=0, out_last=0, scan index=0.
- Slot free means out_valid==0, or out_valid==1 and out_ready==1 (accept this cycle).
- Capture happens when flag==1 and the slot is free.
  - The index is sel in direct mode and the scan index in scan mode.
  - On capture: out_data <= data[idx*W +: W], out_ch <= idx, out_valid <= 1.
  - out_last <= (mode==1 && idx==CH-1).
- No capture when flag==0, or when the word is held (out_valid==1, out_ready==0).
  - If an accept occurs, out_valid <= 0.
  - Otherwise out_valid, out_data, out_ch and out_last are unchanged.
- Held words never change, regardless of data, sel, mode or flag activity.
- Scan index:
  - Advances only on a scan-mode capture.
  - Goes from CH-1 to 0 (wrap), otherwise +1.
  - Forced to 0 on any cycle with mode==0.
- Out-of-range sel (sel >= CH, non-power-of-2 CH): capture with out_data=0 and out_ch=sel.
- Two-state control:
  - EMPTY to FULL on capture.
  - FULL to EMPTY on accept without capture.
  - FULL stays FULL on accept with capture, or on hold.

## Timing
- Latency: data/sel sampled at edge N, so out_valid and out_data are valid after edge N.
- Throughput: one word per clock when flag==1 and out_ready==1.
- Scan with flag and out_ready held high emits channels 0,1,…,CH-1,0,… on consecutive cycles.
  - out_last is high on every CH-th word.
- out_ready is ignored while out_valid==0, and no word is lost.
- Mode switch: the first scan-mode capture is always channel 0.
- Reset mid-transfer clears all outputs immediately (asynchronous). The held word is dropped.

## Configuration
- CHAN_MUX_MASK_EN defined:
  - Adds input ch_mask.
  - In scan mode, a capture takes the first channel j, searched cyclically from the scan index, with ch_mask[j]==1.
  - The scan index then becomes j+1 (mod CH).
  - out_last is set when j is the highest unmasked channel.
  - If ch_mask==0, no capture occurs.
  - Direct mode ignores ch_mask.
- CHAN_MUX_MASK_EN undefined:
  - No ch_mask port.
  - Every channel is scanned, as described above.

## Test plan
- Reset and direct mode, CH=4, W=1:
  - Hold rst_n low, then release.
  - data=4'b1010, mode=0, flag=1, out_ready=1, sel=1.
  - Next cycle: out_data=1, out_ch=1, out_valid=1.
  - sel=2 then gives out_data=0, out_ch=2.
- Flag gating: flag=0 with out_ready=1 → out_valid falls to 0 after one edge, and out_data keeps its last value.
- Backpressure, CH=4, W=8:
  - data={8'h44,8'h33,8'h22,8'h11}, scan mode.
  - out_ready=0 for 3 cycles → out_data=8'h11 and out_ch=0 stay stable.
  - Raise out_ready → sequence 8'h22, 8'h33, 8'h44 (out_last=1), then 8'h11.
- Mode change mid-scan: after channel 2 is emitted, pulse mode=0 for one cycle, then mode=1 → the next scan word is channel 0.
- Async reset during a held word: assert rst_n low between edges → all outputs are 0 immediately.
- With CHAN_MUX_MASK_EN, ch_mask=4'b1010, scan mode → out_ch sequence 1,3,1,3, and out_last=1 on each ch 3. ch_mask=0 → out_valid stays 0.
